// File: rtl/prog_loader.sv
// prog_loader: turns a BASE/LEN/words byte stream into 256x16 RAM writes, then releases the CPU at BASE.
// Latency: LO byte accepted at edge k -> write strobe during k..k+1; sustained 1 word per 3 cycles.
// Backpressure: o_in_ready low in INIT/WRITE/RUN/ERR; optional checksum byte enabled by PROG_LOADER_CSUM_EN.
`timescale 1ns/1ps

module prog_loader (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_reload,
    output logic        o_ram_w_en,
    output logic [7:0]  o_ram_w_addr,
    output logic [15:0] o_ram_w_data,
    output logic        o_cpu_rst_n,
    output logic [7:0]  o_start_pc,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [3:0] {
        S_INIT  = 4'd0,
        S_ADDR  = 4'd1,
        S_LEN   = 4'd2,
        S_HI    = 4'd3,
        S_LO    = 4'd4,
        S_WRITE = 4'd5,
        S_CSUM  = 4'd6,
        S_RUN   = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    // Where the stream goes once the last word (or an empty LEN) is consumed.
`ifdef PROG_LOADER_CSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_RUN;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_base;
    logic [7:0]  r_len;
    logic [7:0]  r_idx;
    logic [7:0]  r_hi;
    logic        r_in_ready;
    logic        r_ram_w_en;
    logic [7:0]  r_ram_w_addr;
    logic [15:0] r_ram_w_data;
    logic        r_cpu_rst_n;
    logic [7:0]  r_start_pc;
    logic        r_done;
    logic        w_accept;
    logic [7:0]  w_idx_inc;
    logic        w_more;

    assign w_accept  = i_in_valid & r_in_ready;
    assign w_idx_inc = r_idx + 8'd1;
    assign w_more    = (w_idx_inc != r_len);

`ifdef PROG_LOADER_CSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_nxt;
    logic       r_err;
    assign w_sum_nxt = r_sum + i_in_data;
`endif

    // States in which a stream byte may be taken.
    function automatic logic f_ready(input state_t s);
        case (s)
            S_ADDR, S_LEN, S_HI, S_LO: f_ready = 1'b1;
`ifdef PROG_LOADER_CSUM_EN
            S_CSUM:                    f_ready = 1'b1;
`endif
            default:                   f_ready = 1'b0;
        endcase
    endfunction

    // Next-state selection; byte-driven states stall while no byte is accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  w_state_nxt = S_ADDR;
            S_ADDR:  if (w_accept) w_state_nxt = S_LEN;
            S_LEN:   if (w_accept) w_state_nxt = (i_in_data != 8'd0) ? S_HI : S_TAIL;
            S_HI:    if (w_accept) w_state_nxt = S_LO;
            S_LO:    if (w_accept) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_more ? S_HI : S_TAIL;
`ifdef PROG_LOADER_CSUM_EN
            S_CSUM:  if (w_accept) w_state_nxt = (w_sum_nxt == 8'd0) ? S_RUN : S_ERR;
`endif
            S_RUN, S_ERR: if (i_reload) w_state_nxt = S_ADDR;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // State register plus outputs registered from the next state so they line up with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_INIT;
            r_in_ready   <= 1'b0;
            r_ram_w_en   <= 1'b0;
            r_ram_w_addr <= 8'h00;
            r_ram_w_data <= 16'h0000;
            r_cpu_rst_n  <= 1'b0;
            r_start_pc   <= 8'h00;
            r_done       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= f_ready(w_state_nxt);
            r_cpu_rst_n <= (w_state_nxt == S_RUN);
            r_done      <= (w_state_nxt == S_RUN);
            r_ram_w_en  <= (r_state == S_LO) && w_accept;
            if ((r_state == S_LO) && w_accept) begin
                r_ram_w_addr <= r_base + r_idx;
                r_ram_w_data <= {r_hi, i_in_data};
            end
            if (w_state_nxt == S_RUN) begin
                r_start_pc <= r_base;
            end
        end
    end

    // Header fields, word index and the pending high byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base <= 8'h00;
            r_len  <= 8'h00;
            r_idx  <= 8'h00;
            r_hi   <= 8'h00;
        end else begin
            if ((r_state == S_ADDR) && w_accept) begin
                r_base <= i_in_data;
            end
            if ((r_state == S_LEN) && w_accept) begin
                r_len <= i_in_data;
                r_idx <= 8'h00;
            end
            if ((r_state == S_HI) && w_accept) begin
                r_hi <= i_in_data;
            end
            if (r_state == S_WRITE) begin
                r_idx <= w_idx_inc;
            end
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    // Running byte sum over the whole stream; restarts whenever a new stream begins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= 8'h00;
            r_err <= 1'b0;
        end else begin
            r_err <= (w_state_nxt == S_ERR);
            if ((w_state_nxt == S_ADDR) && (r_state != S_ADDR)) begin
                r_sum <= 8'h00;
            end else if (w_accept) begin
                r_sum <= w_sum_nxt;
            end
        end
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_in_ready   = r_in_ready;
    assign o_ram_w_en   = r_ram_w_en;
    assign o_ram_w_addr = r_ram_w_addr;
    assign o_ram_w_data = r_ram_w_data;
    assign o_cpu_rst_n  = r_cpu_rst_n;
    assign o_start_pc   = r_start_pc;
    assign o_done       = r_done;

endmodule
